ram_burst_ctrl: RTL and testbench

Parametrised single-port synchronous RAM with a burst command engine, generalising the fixed 128x8 direct-access memory.
- A command (read/write, start address, length) runs an auto-incrementing burst with wrap-around.
- Write data and read data move over valid/ready streams; the read path honours backpressure.
- Sits between the chip-level pin mux and the memory array, replacing per-cycle address driving.

---
 rtl/ram_burst_pkg.sv | 11 +
 rtl/ram_burst_if.sv | 32 +++
 rtl/ram_burst_rdbuf.sv | 42 ++++
 rtl/ram_burst_ctrl.sv | 115 +++++++++++
 tb/tb_ram_burst_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_burst_pkg.sv
// Shared constants for the burst RAM controller: FSM state encoding and
// read output buffer depth.
package ram_burst_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/ram_burst_if.sv
// Command, write-stream and read-stream bundle of the burst RAM controller.
// The master drives commands and write data; the slave is the controller.
interface ram_burst_if #(
  parameter int ADDR_W = 7,
  parameter int LEN_W  = 7,
  parameter int WIDTH  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [WIDTH-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err
  );
endinterface

// File: rtl/ram_burst_rdbuf.sv
// Two-entry valid/ready output FIFO for read data; count feeds the issue
// throttle in the controller so the buffer can never overflow.
module ram_burst_rdbuf
  import ram_burst_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] slot [RD_BUF_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  // Empty buffer presents zero so the read port is quiet out of reset.
  assign out_data  = out_valid ? slot[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_valid) wr_ptr <= ~wr_ptr;
      if (pop)        rd_ptr <= ~rd_ptr;
      count <= count + 2'(push_valid) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_valid) slot[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ram_burst_ctrl.sv
// Single-port RAM fronted by a burst command engine: each command runs an
// auto-incrementing, wrapping read or write burst over valid/ready streams.
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter  int DEPTH  = 128,
  parameter  int WIDTH  = 8,
  parameter  int LEN_W  = 7,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        rst,
  ram_burst_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W:0]    iss_left;
  logic              done_q;
  logic              err_q;
  logic              cmd_fire;
  logic              addr_ok;
  logic              wr_fire;
  logic              rd_fire;
  logic              issue;
  logic              buf_valid;
  logic [WIDTH-1:0]  buf_data;
  logic [1:0]        buf_count;
  logic [WIDTH-1:0]  rd_word;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  assign bus.cmd_ready = !rst && (state == ST_IDLE);
  assign bus.wr_ready  = !rst && (state == ST_WRITE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rd_valid  = buf_valid;
  assign bus.rd_data   = buf_data;

  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
  assign addr_ok  = ({1'b0, bus.cmd_addr} < DEPTH_EXT);
  assign wr_fire  = bus.wr_valid && bus.wr_ready;
  assign rd_fire  = buf_valid && bus.rd_ready;
  // The array's read register is the FIFO slot itself, so nothing is ever in
  // flight outside the buffer and its count alone throttles issue.
  assign issue    = !rst && (state == ST_READ) && (iss_left != '0) &&
                    (buf_count < 2'(RD_BUF_DEPTH));
  assign rd_word  = mem[addr];

  // Control: FSM and completion/reject pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            if (!addr_ok)           err_q <= 1'b1;
            else if (bus.cmd_write) state <= ST_WRITE;
            else                    state <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (wr_fire && cnt == '0) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        ST_READ: begin
          if (rd_fire && cnt == '0) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: burst address, beat counters and the memory array
  always_ff @(posedge clk) begin
    if (cmd_fire && addr_ok) begin
      addr     <= bus.cmd_addr;
      cnt      <= bus.cmd_len;
      iss_left <= {1'b0, bus.cmd_len} + (LEN_W+1)'(1);
    end else begin
      if (wr_fire || issue) addr <= next_addr(addr);
      if (wr_fire || rd_fire) cnt <= cnt - LEN_W'(1);
      if (issue) iss_left <= iss_left - (LEN_W+1)'(1);
    end
    if (wr_fire) mem[addr] <= bus.wr_data;
  end

  ram_burst_rdbuf #(.WIDTH(WIDTH)) u_rdbuf (
    .clk        (clk),
    .rst        (rst),
    .push_valid (issue),
    .push_data  (rd_word),
    .out_valid  (buf_valid),
    .out_ready  (bus.rd_ready),
    .out_data   (buf_data),
    .count      (buf_count)
  );
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Randomised bench for ram_burst_ctrl with a word-array memory model; a
// non-power-of-2 depth makes out-of-range addresses representable.
module tb_ram_burst_ctrl;
  localparam int DEPTH = 100;
  localparam int WIDTH = 8;
  localparam int LEN_W = 7;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [WIDTH-1:0] model_mem [DEPTH];

  ram_burst_if #(.ADDR_W(AW), .LEN_W(LEN_W), .WIDTH(WIDTH)) bus ();

  ram_burst_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a command and returns one step after the handshake edge.
  task automatic send_cmd(input logic w, input int a, input int len);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = AW'(a);
    bus.cmd_len   = LEN_W'(len);
    while (bus.cmd_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_write(input int a, input int len, input logic [WIDTH-1:0] data_q[$],
                          input int stall_beat, input int stall_len);
    int n = len + 1;
    send_cmd(1'b1, a, len);
    for (int i = 0; i < n; i++) begin
      if (i == stall_beat) begin
        bus.wr_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          bus.wr_data = WIDTH'($urandom);
          checks++;
          if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL wr_stall: busy=%b done=%b required 1/0", bus.busy, bus.done);
          end
          tick();
        end
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = data_q[i];
      checks++;
      if (bus.wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL wr_ready: beat %0d wr_ready=%b required 1", i, bus.wr_ready);
      end
      model_mem[(a + i) % DEPTH] = data_q[i];
      tick();
    end
    bus.wr_valid = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: done=%b busy=%b wr_ready=%b required 1/0/0",
               bus.done, bus.busy, bus.wr_ready);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL wr_done_pulse: done=%b required 0", bus.done);
    end
  endtask

  // mode 0: rd_ready held high, 1: pattern 1,0,0 repeating, 2: random.
  // stop_after > 0 abandons the burst after that many words are taken.
  task automatic do_read(input int a, input int len, input int mode, input int stop_after);
    int n = len + 1;
    int idx = 0;
    int cyc = 0;
    logic rdy;
    logic hold = 1'b0;
    logic [WIDTH-1:0] held = '0;
    logic [WIDTH-1:0] exp_q [$];
    for (int i = 0; i < n; i++) exp_q.push_back(model_mem[(a + i) % DEPTH]);
    send_cmd(1'b0, a, len);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_lat1: rd_valid=%b busy=%b required 0/1", bus.rd_valid, bus.busy);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_lat2: rd_valid=%b required 1 two cycles after handshake", bus.rd_valid);
    end
    while (idx < n && cyc < 4000 && !(stop_after > 0 && idx >= stop_after)) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      bus.rd_ready = rdy;
      checks++;
      if (bus.rd_valid === 1'b1 && bus.rd_data !== exp_q[idx]) begin
        errors++;
        $display("FAIL rd_data: word %0d got %h required %h", idx, bus.rd_data, exp_q[idx]);
      end
      checks++;
      if (hold && (bus.rd_valid !== 1'b1 || bus.rd_data !== held)) begin
        errors++;
        $display("FAIL rd_hold: rd_valid=%b rd_data=%h required 1/%h", bus.rd_valid, bus.rd_data, held);
      end
      checks++;
      if ((mode == 0 && bus.rd_valid !== 1'b1) || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL rd_stream: rd_valid=%b done=%b required 1/0", bus.rd_valid, bus.done);
      end
      checks++;
      if (dut.u_rdbuf.count > 2'd2) begin
        errors++;
        $display("FAIL rd_occupancy: count=%0d required <=2", dut.u_rdbuf.count);
      end
      hold = bus.rd_valid && !rdy;
      held = bus.rd_data;
      if (bus.rd_valid === 1'b1 && rdy) idx++;
      tick();
      cyc++;
    end
    bus.rd_ready = 1'b0;
    if (stop_after > 0 && idx >= stop_after) return;
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL rd_timeout: words %0d required %0d", idx, n);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_done: done=%b busy=%b cmd_ready=%b required 1/0/1",
               bus.done, bus.busy, bus.cmd_ready);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_done_pulse: done=%b rd_valid=%b required 0/0", bus.done, bus.rd_valid);
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.wr_ready !== 1'b0 || bus.rd_valid !== 1'b0 ||
        bus.rd_data !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: cmd_ready=%b wr_ready=%b rd_valid=%b rd_data=%h busy=%b done=%b err=%b required all 0",
               bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.busy, bus.done, bus.err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] q [$];
    for (int i = 0; i < DEPTH; i++) q.push_back(WIDTH'($urandom));
    do_write(0, DEPTH - 1, q, -1, 0);
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] q [$];
    q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_write(16, 3, q, -1, 0);
    do_read(16, 3, 0, 0);
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] q [$];
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(DEPTH - 2, 3, q, -1, 0);
    checks++;
    if (model_mem[DEPTH-1] !== 8'h22 || model_mem[0] !== 8'h33) begin
      errors++;
      $display("FAIL wrap_model: [last]=%h [0]=%h required 22/33", model_mem[DEPTH-1], model_mem[0]);
    end
    do_read(DEPTH - 2, 3, 0, 0);
  endtask

  task automatic test_backpressure();
    do_read(int'($urandom_range(0, DEPTH - 1)), 7, 1, 0);
    do_read(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)), 2, 0);
  endtask

  task automatic test_error();
    for (int k = 0; k < 2; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = WIDTH'($urandom);
      send_cmd(1'b1, (k == 0) ? DEPTH : int'($urandom_range(DEPTH, (1 << AW) - 1)), 3);
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse: err=%b busy=%b cmd_ready=%b wr_ready=%b required 1/0/1/0",
                 bus.err, bus.busy, bus.cmd_ready, bus.wr_ready);
      end
      tick();
      checks++;
      if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL err_clear: err=%b busy=%b required 0/0", bus.err, bus.busy);
      end
      bus.wr_valid = 1'b0;
    end
    do_read(0, DEPTH - 1, 0, 0);
  endtask

  task automatic test_write_stall();
    logic [WIDTH-1:0] q [$];
    for (int i = 0; i < 10; i++) q.push_back(WIDTH'($urandom));
    do_write(40, 9, q, 4, 5);
    do_read(38, 13, 0, 0);
  endtask

  task automatic test_reset_mid_read();
    do_read(5, 7, 0, 2);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_cmd_ready: cmd_ready=%b required 0 during rst", bus.cmd_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_read: rd_valid=%b cmd_ready=%b busy=%b done=%b required 0/1/0/0",
               bus.rd_valid, bus.cmd_ready, bus.busy, bus.done);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done: done=%b rd_valid=%b required 0/0", bus.done, bus.rd_valid);
    end
    do_read(5, 7, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] q [$];
    int a, len;
    for (int it = 0; it < 8; it++) begin
      a   = int'($urandom_range(0, DEPTH - 1));
      len = int'($urandom_range(0, (1 << LEN_W) - 1));
      if ($urandom_range(0, 1) == 1) begin
        q = {};
        for (int i = 0; i <= len; i++) q.push_back(WIDTH'($urandom));
        do_write(a, len, q, int'($urandom_range(0, len + 3)), int'($urandom_range(1, 4)));
      end else begin
        do_read(a, len, int'($urandom_range(0, 2)), 0);
      end
    end
    do_read(0, (1 << LEN_W) - 1, 2, 0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_wrap();
    test_backpressure();
    test_error();
    test_write_stall();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
